// File: rtl/scu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scu_sequencer: fetches ROM words from address 0 upward, issues each one  |
// | to the SCU with a Run pulse and waits for Done. SEQ_WATCHDOG_EN enables  |
// | the WAIT-state watchdog.                                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scu_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int LAST_ADDR   = 15,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              Pclk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomData,
  output logic [DATA_W-1:0] Instr,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic [ADDR_W-1:0] Pc,
  output logic              Timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_PC = ADDR_W'(LAST_ADDR);

  state_t r_state;
  logic   r_done_q;
  logic   r_stop_req;
  logic   w_done_edge;
  logic   w_start_ok;

  assign w_done_edge = Done & ~r_done_q;
  assign w_start_ok  = Start & ~Stop;
  assign RomAddr     = Pc;

`ifdef SEQ_WATCHDOG_EN
  localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
  logic [c_WDOG_W-1:0] r_wdog;
  logic                r_timeout;
  assign Timeout = r_timeout;
`else
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Pclk or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      Pc         <= '0;
      Instr      <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      r_stop_req <= 1'b0;
      r_done_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_done_q <= Done;
      Run      <= 1'b0;
      if (Busy && Stop) r_stop_req <= 1'b1;

      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (w_start_ok) begin
            r_state    <= S_FETCH;
            Pc         <= '0;
            Halted     <= 1'b0;
            Busy       <= 1'b1;
            r_stop_req <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_timeout  <= 1'b0;
`endif
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          Instr   <= RomData;
          Run     <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef SEQ_WATCHDOG_EN
          r_wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (w_done_edge) begin
            r_state <= S_NEXT;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (r_wdog == c_WDOG_LAST) begin
            // SCU never answered: abandon the program, keep Pc for diagnosis
            r_timeout  <= 1'b1;
            r_state    <= S_IDLE;
            Busy       <= 1'b0;
            r_stop_req <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        S_NEXT: begin
          if (r_stop_req) begin
            r_state    <= S_IDLE;
            Busy       <= 1'b0;
            r_stop_req <= 1'b0;
          end else if (Pc == c_LAST_PC) begin
            r_state    <= S_HALT;
            Busy       <= 1'b0;
            Halted     <= 1'b1;
            r_stop_req <= 1'b0;
          end else begin
            Pc      <= Pc + 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scu_sequencer: randomized scoreboard bench for scu_sequencer.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scu_sequencer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int LAST   = 15;

  logic              Pclk = 1'b0;
  logic              Resetn = 1'b0;
  logic              Start = 1'b0;
  logic              Stop = 1'b0;
  logic [ADDR_W-1:0] RomAddr;
  logic [DATA_W-1:0] RomData;
  logic [DATA_W-1:0] Instr;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Halted;
  logic [ADDR_W-1:0] Pc;
  logic              Timeout;

  logic done_auto  = 1'b0;
  logic done_force = 1'b0;
  logic scu_auto   = 1'b1;
  assign Done = done_auto | done_force;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } exp_t;

  exp_t              sb_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] rom[0:LAST];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                done_cyc = 0;
  bit                lat_arm  = 1'b0;
  logic              prev_done = 1'b0;
  int                scu_cnt  = 0;

  scu_sequencer dut (
    .Pclk    (Pclk),
    .Resetn  (Resetn),
    .Start   (Start),
    .Stop    (Stop),
    .RomAddr (RomAddr),
    .RomData (RomData),
    .Instr   (Instr),
    .Run     (Run),
    .Done    (Done),
    .Busy    (Busy),
    .Halted  (Halted),
    .Pc      (Pc),
    .Timeout (Timeout)
  );

  always #5 Pclk = ~Pclk;

  // synchronous ROM: data for the sampled address appears one edge later
  always @(posedge Pclk) RomData <= rom[RomAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a program run from lo to hi executes ROM words in address order.
  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      exp_t e;
      e.pc    = ADDR_W'(a);
      e.instr = rom[a];
      sb_q.push_back(e);
    end
  endtask

  task automatic new_rom();
    for (int i = 0; i <= LAST; i++) rom[i] = DATA_W'($urandom_range(1, 65535));
  endtask

  // SCU model: one-cycle Done pulse 1..4 cycles after each Run
  always @(posedge Pclk) begin
    #2;
    done_auto = 1'b0;
    if (!Resetn || !scu_auto) scu_cnt = 0;
    else if (Run) scu_cnt = $urandom_range(1, 4);
    else if (scu_cnt > 0) begin
      scu_cnt--;
      if (scu_cnt == 0) done_auto = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every Run and checks Done-edge-to-Run latency
  always @(posedge Pclk) begin
    #1;
    cyc++;
    if (Start) lat_arm = 1'b0;
    if (Run) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_run: got Run at pc=%0d expected no Run", Pc);
      end else begin
        mon_e = sb_q.pop_front();
        check("run_pc", 32'(Pc), 32'(mon_e.pc));
        check("run_instr", 32'(Instr), 32'(mon_e.instr));
      end
      if (lat_arm) begin
        check("done_to_run", cyc - done_cyc, 4);
        lat_arm = 1'b0;
      end
    end
    // Done is driven mid-cycle, so its first high cycle began one edge before this sample
    if (Done && !prev_done && Resetn) begin
      done_cyc = cyc - 1;
      lat_arm  = 1'b1;
    end
    prev_done = Done;
  end

  task automatic start_prog(input string name);
    int i;
    @(posedge Pclk); #2 Start = 1'b1;
    @(posedge Pclk); #2 Start = 1'b0;
    // Start was sampled at the edge just passed: FETCH, LOAD, then Run two edges later
    for (i = 1; i <= 6; i++) begin
      @(posedge Pclk); #2;
      if (Run) break;
    end
    check(name, i, 2);
  endtask

  task automatic wait_run(input int pc, input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge Pclk); #2;
      if (Run && Pc == ADDR_W'(pc)) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    bit idle = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge Pclk); #2;
      if (!Busy) begin
        idle = 1'b1;
        break;
      end
    end
    check(name, 32'(idle), 1);
  endtask

  task automatic start_stop_together(input string name, input int pc, input bit halted);
    @(posedge Pclk); #2 Start = 1'b1; Stop = 1'b1;
    @(posedge Pclk); #2 Start = 1'b0; Stop = 1'b0;
    repeat (5) @(posedge Pclk);
    #2;
    check({name, "_busy"}, 32'(Busy), 0);
    check({name, "_pc"}, 32'(Pc), 32'(pc));
    check({name, "_halted"}, 32'(Halted), 32'(halted));
  endtask

  initial begin
    int s;
    new_rom();
    repeat (2) @(posedge Pclk);
    #1;
    check("rst_pc", 32'(Pc), 0);
    check("rst_romaddr", 32'(RomAddr), 0);
    check("rst_instr", 32'(Instr), 0);
    check("rst_run", 32'(Run), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_halted", 32'(Halted), 0);
    check("rst_timeout", 32'(Timeout), 0);
    #1 Resetn = 1'b1;

    // full program to halt
    push_range(0, LAST);
    start_prog("s1_start_lat");
    wait_idle(400, "s1_idle");
    check("s1_halted", 32'(Halted), 1);
    check("s1_pc", 32'(Pc), LAST);
    check("s1_sb_empty", sb_q.size(), 0);
    start_stop_together("s4_halt_startstop", LAST, 1'b1);

    // Stop during WAIT of a random address
    new_rom();
    s = $urandom_range(1, 14);
    push_range(0, s);
    start_prog("s2_start_lat");
    wait_run(s, 200, "s2_reach_stop_pc");
    @(posedge Pclk); #2 Stop = 1'b1;
    wait_idle(40, "s2_idle");
    Stop = 1'b0;
    repeat (6) @(posedge Pclk);
    #2;
    check("s2_pc", 32'(Pc), 32'(s));
    check("s2_halted", 32'(Halted), 0);
    check("s2_sb_empty", sb_q.size(), 0);
    start_stop_together("s4_idle_startstop", s, 1'b0);

    // Start pulses while busy must not disturb the program
    new_rom();
    push_range(0, LAST);
    start_prog("s4_start_lat");
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(3, 15)) @(posedge Pclk);
      #2;
      if (Busy) begin
        Start = 1'b1;
        @(posedge Pclk); #2 Start = 1'b0;
      end
    end
    wait_idle(400, "s4_idle");
    check("s4_pc", 32'(Pc), LAST);
    check("s4_halted", 32'(Halted), 1);
    check("s4_sb_empty", sb_q.size(), 0);

    // Done held high across two instructions
    scu_auto = 1'b0;
    push_range(0, 1);
    start_prog("s3_start_lat");
    repeat (2) @(posedge Pclk);
    #2 done_force = 1'b1;
    wait_run(1, 20, "s3_run1");
    repeat (10) @(posedge Pclk);
    #2;
    check("s3_stuck_busy", 32'(Busy), 1);
    check("s3_stuck_pc", 32'(Pc), 1);
    check("s3_sb_empty", sb_q.size(), 0);
    push_range(2, 2);
    done_force = 1'b0;
    @(posedge Pclk); #2 done_force = 1'b1;
    @(posedge Pclk); #2 done_force = 1'b0;
    wait_run(2, 20, "s3_run2");
    Stop = 1'b1;
    repeat (2) @(posedge Pclk);
    #2 done_force = 1'b1;
    @(posedge Pclk); #2 done_force = 1'b0;
    wait_idle(20, "s3_idle");
    Stop = 1'b0;
    check("s3_pc", 32'(Pc), 2);
    scu_auto = 1'b1;

    // asynchronous reset in WAIT of address 7
    new_rom();
    push_range(0, 7);
    start_prog("s5_start_lat");
    wait_run(7, 200, "s5_reach_pc7");
    @(posedge Pclk); #3 Resetn = 1'b0;
    #1;
    check("s5_rst_pc", 32'(Pc), 0);
    check("s5_rst_instr", 32'(Instr), 0);
    check("s5_rst_busy", 32'(Busy), 0);
    check("s5_rst_run", 32'(Run), 0);
    check("s5_rst_halted", 32'(Halted), 0);
    @(posedge Pclk); #2 Resetn = 1'b1;
    push_range(0, LAST);
    start_prog("s5_restart_lat");
    wait_idle(400, "s5_idle");
    check("s5_pc", 32'(Pc), LAST);
    check("s5_halted", 32'(Halted), 1);

    // Done never rises
    scu_auto = 1'b0;
    push_range(0, 0);
    start_prog("s6_start_lat");
`ifdef SEQ_WATCHDOG_EN
    repeat (64) @(posedge Pclk);
    #1;
    check("s6_pre_timeout", 32'(Timeout), 0);
    check("s6_pre_busy", 32'(Busy), 1);
    @(posedge Pclk); #1;
    check("s6_timeout", 32'(Timeout), 1);
    check("s6_busy", 32'(Busy), 0);
    check("s6_pc", 32'(Pc), 0);
    scu_auto = 1'b1;
    push_range(0, LAST);
    start_prog("s6_restart_lat");
    check("s6_timeout_clr", 32'(Timeout), 0);
    wait_idle(400, "s6_idle");
    check("s6_halted", 32'(Halted), 1);
`else
    repeat (80) @(posedge Pclk);
    #2;
    check("s6_busy", 32'(Busy), 1);
    check("s6_timeout", 32'(Timeout), 0);
    Stop = 1'b1;
    @(posedge Pclk); #2 done_force = 1'b1;
    @(posedge Pclk); #2 done_force = 1'b0;
    wait_idle(20, "s6_idle");
    Stop = 1'b0;
    check("s6_pc", 32'(Pc), 0);
    scu_auto = 1'b1;
`endif

    repeat (5) @(posedge Pclk);
    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire
